// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: captures retired register writes from the CPU writeback trace
// port, tags each with a sequence number and queues them for a valid/ready
// consumer. A full queue drops records and counts them; the CPU is never stalled.
module wb_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       debug_wb_pc,
  input  logic [3:0]        debug_wb_rf_we,
  input  logic [4:0]        debug_wb_rf_wnum,
  input  logic [31:0]       debug_wb_rf_wdata,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_seq,
  output logic [31:0]       out_pc,
  output logic [3:0]        out_we,
  output logic [4:0]        out_wnum,
  output logic [31:0]       out_wdata,
  output logic [AW:0]       fifo_count,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int          REC_W    = 32 + 32 + 4 + 5 + 32;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [31:0]      seq;

  logic cap;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Drop counter sticks at all-ones instead of wrapping back to a small value.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  // Capture/push/pop/drop decisions; a full queue still accepts when the head leaves this cycle.
  always_comb begin
    cap  = (|debug_wb_rf_we) && (debug_wb_rf_wnum != 5'd0);
    full = (count == FULL_CNT);
    pop  = out_valid && out_ready;
    push = cap && (!full || pop);
    drop = cap && full && !pop;
  end

  // Show-ahead head: outputs read the storage at the read pointer, so out_ready only acts via state.
  always_comb begin
    out_valid  = (count != '0);
    fifo_count = count;
    {out_seq, out_pc, out_we, out_wnum, out_wdata} = mem[rd_ptr];
  end

  // Record storage; cleared on reset so the head reads zero until the first record lands.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !clear) begin
      mem[wr_ptr] <= {seq, debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata};
    end
  end

  // Pointers, occupancy, sequence and drop bookkeeping; clear overrides any concurrent push/pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (cap)  seq    <= seq + 32'd1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

endmodule
